// File: rtl/fft_power_spec.sv
// Streaming power-spectrum stage: |X[k]|^2 for the half-spectrum bins 0..NFFT/2,
// with bin index / end-of-frame tagging, frame counting and frame-length checking.
module fft_power_spec #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NFFT  = 512,
  parameter int unsigned IDX_W = 9,
  parameter int unsigned OUT_W = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_real,
  input  logic signed [WIDTH-1:0] s_imag,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OUT_W-1:0]        m_power,
  output logic [IDX_W-1:0]        m_index,
  output logic                    m_last,
  output logic [15:0]             frame_cnt,
  output logic                    len_err,
  input  logic                    err_clr
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(NFFT / 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFFT - 1);

  logic [IDX_W-1:0]     cnt;
  logic                 adv;
  logic                 xfer;
  logic                 keep;
  logic                 at_end;
  logic                 frame_end;
  logic                 len_bad;
  logic signed [PW-1:0] re_ext;
  logic signed [PW-1:0] im_ext;

  logic                 s1_valid;
  logic signed [PW-1:0] s1_rr;
  logic signed [PW-1:0] s1_ii;
  logic [IDX_W-1:0]     s1_idx;
  logic                 s1_last;

  // Whole pipeline moves together; a stalled output freezes both stages.
  always_comb begin
    adv       = !m_valid || m_ready;
    s_ready   = adv;
    xfer      = s_valid && adv;
    keep      = (cnt <= HALF_IDX);
    at_end    = (cnt == LAST_IDX);
    frame_end = xfer && (s_last || at_end);
    len_bad   = xfer && (s_last != at_end);
    re_ext    = $signed({{WIDTH{s_real[WIDTH-1]}}, s_real});
    im_ext    = $signed({{WIDTH{s_imag[WIDTH-1]}}, s_imag});
  end

  // Input bin counter, frame counter and sticky length error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      frame_cnt <= '0;
      len_err   <= 1'b0;
    end else begin
      if (frame_end) begin
        cnt       <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (xfer) begin
        cnt <= cnt + IDX_W'(1);
      end
      if (len_bad) begin
        len_err <= 1'b1;
      end else if (err_clr) begin
        len_err <= 1'b0;
      end
    end
  end

  // Stage 1: squares; bins above NFFT/2 are accepted but enter as bubbles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_rr    <= '0;
      s1_ii    <= '0;
      s1_idx   <= '0;
      s1_last  <= 1'b0;
    end else if (adv) begin
      s1_valid <= xfer && keep;
      s1_rr    <= re_ext * re_ext;
      s1_ii    <= im_ext * im_ext;
      s1_idx   <= cnt;
      s1_last  <= (cnt == HALF_IDX) || s_last;
    end
  end

  // Stage 2: unsigned sum; both squares are non-negative so no overflow occurs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid <= 1'b0;
      m_power <= '0;
      m_index <= '0;
      m_last  <= 1'b0;
    end else if (adv) begin
      m_valid <= s1_valid;
      if (s1_valid) begin
        m_power <= OUT_W'($unsigned(s1_rr)) + OUT_W'($unsigned(s1_ii));
        m_index <= s1_idx;
        m_last  <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_fft_power_spec.sv
// Directed self-checking bench for fft_power_spec: latency, extremes, full and
// short frames, backpressure, err_clr behaviour and mid-frame reset.
module tb_fft_power_spec;

  logic               clk;
  logic               resetn;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_real;
  logic signed [15:0] s_imag;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic [31:0]        m_power;
  logic [8:0]         m_index;
  logic               m_last;
  logic [15:0]        frame_cnt;
  logic               len_err;
  logic               err_clr;

  typedef struct packed {
    logic        last;
    logic [8:0]  idx;
    logic [31:0] pwr;
  } out_t;

  out_t q[$];
  int   checks   = 0;
  int   failures = 0;

  fft_power_spec dut (
    .clk      (clk),
    .resetn   (resetn),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_real   (s_real),
    .s_imag   (s_imag),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_power  (m_power),
    .m_index  (m_index),
    .m_last   (m_last),
    .frame_cnt(frame_cnt),
    .len_err  (len_err),
    .err_clr  (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output transfer, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn && m_valid && m_ready) q.push_back({m_last, m_index, m_power});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int re, input int im, input logic last);
    s_real  = 16'(re);
    s_imag  = 16'(im);
    s_last  = last;
    s_valid = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk_half_frame(input string tag);
    chk({tag, "_len"}, 64'(q.size()), 64'd257);
    for (int i = 0; i < 257; i++) begin
      chk($sformatf("%s_pwr%0d", tag, i), 64'(q[i].pwr), 64'(i * i));
      chk($sformatf("%s_idx%0d", tag, i), 64'(q[i].idx), 64'(i));
      chk($sformatf("%s_last%0d", tag, i), 64'(q[i].last), 64'(i == 256));
    end
  endtask

  initial begin
    resetn = 1'b0; s_valid = 1'b0; s_real = '0; s_imag = '0; s_last = 1'b0;
    m_ready = 1'b1; err_clr = 1'b0;
    #2;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_power", 64'(m_power), 64'd0);
    chk("rst_m_index", 64'(m_index), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    step();
    resetn = 1'b1;
    step();

    // Single bin 3+4j at index 0: visible after the second edge.
    send(3, 4, 1'b0);
    s_valid = 1'b0;
    chk("lat1_m_valid", 64'(m_valid), 64'd0);
    step();
    chk("lat2_m_valid", 64'(m_valid), 64'd1);
    chk("single_pwr", 64'(m_power), 64'd25);
    chk("single_idx", 64'(m_index), 64'd0);
    chk("single_last", 64'(m_last), 64'd0);
    idle(3);
    q.delete();

    // Extremes at indices 1 and 2.
    send(-32768, -32768, 1'b0);
    send(32767, 0, 1'b0);
    idle(3);
    chk("ext_len", 64'(q.size()), 64'd2);
    chk("ext_neg_pwr", 64'(q[0].pwr), 64'h8000_0000);
    chk("ext_neg_idx", 64'(q[0].idx), 64'd1);
    chk("ext_pos_pwr", 64'(q[1].pwr), 64'h3FFF_0001);
    chk("ext_pos_idx", 64'(q[1].idx), 64'd2);

    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
    q.delete();

    // Full frame without stalls.
    for (int i = 0; i < 512; i++) send(i, 0, i == 511);
    idle(3);
    chk_half_frame("full");
    chk("full_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("full_len_err", 64'(len_err), 64'd0);
    q.delete();

    // Same frame with a 5-cycle stall while bin 100 is presented; bin 98 sits on m_*.
    for (int i = 0; i < 512; i++) begin
      if (i == 100) begin
        m_ready = 1'b0;
        #1;
        chk("bp_s_ready_now", 64'(s_ready), 64'd0);
        for (int c = 0; c < 5; c++) begin
          step();
          chk($sformatf("bp_s_ready%0d", c), 64'(s_ready), 64'd0);
          chk($sformatf("bp_m_valid%0d", c), 64'(m_valid), 64'd1);
          chk($sformatf("bp_m_index%0d", c), 64'(m_index), 64'd98);
          chk($sformatf("bp_m_power%0d", c), 64'(m_power), 64'd9604);
          chk($sformatf("bp_m_last%0d", c), 64'(m_last), 64'd0);
        end
        m_ready = 1'b1;
      end
      send(i, 0, i == 511);
    end
    idle(3);
    chk_half_frame("bp");
    chk("bp_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("bp_len_err", 64'(len_err), 64'd0);
    q.delete();

    // Short frame ending at index 99.
    for (int i = 0; i < 100; i++) send(i, i, i == 99);
    idle(3);
    chk("short_len", 64'(q.size()), 64'd100);
    for (int i = 0; i < 100; i++) begin
      chk($sformatf("short_pwr%0d", i), 64'(q[i].pwr), 64'(2 * i * i));
      chk($sformatf("short_idx%0d", i), 64'(q[i].idx), 64'(i));
      chk($sformatf("short_last%0d", i), 64'(q[i].last), 64'(i == 99));
    end
    chk("short_len_err", 64'(len_err), 64'd1);
    chk("short_frame_cnt", 64'(frame_cnt), 64'd3);
    q.delete();
    send(5, 0, 1'b0);
    idle(3);
    chk("next_idx", 64'(q[0].idx), 64'd0);
    chk("next_pwr", 64'(q[0].pwr), 64'd25);
    chk("sticky_len_err", 64'(len_err), 64'd1);

    // err_clr loses to a simultaneous set (s_last at index 1).
    err_clr = 1'b1;
    send(0, 0, 1'b1);
    err_clr = 1'b0;
    s_valid = 1'b0;
    chk("clr_prio_len_err", 64'(len_err), 64'd1);
    chk("clr_prio_frame_cnt", 64'(frame_cnt), 64'd4);
    idle(2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_len_err", 64'(len_err), 64'd0);
    idle(2);

    // Reset while bin 40 is presented.
    for (int i = 0; i < 40; i++) send(i, 1, 1'b0);
    resetn = 1'b0;
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
    s_valid = 1'b0;
    step();
    resetn = 1'b1;
    step();
    q.delete();
    send(7, 1, 1'b0);
    idle(3);
    chk("midrst_len", 64'(q.size()), 64'd1);
    chk("midrst_idx", 64'(q[0].idx), 64'd0);
    chk("midrst_pwr", 64'(q[0].pwr), 64'd50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
